// File: rtl/dmem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu_if
// Brief    : Core request/response and data-memory signals of the load/store unit
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_we;

    // Core and memory side, as seen by the environment around the LSU
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Brief    : Single-outstanding load/store unit with sub-word RMW stores
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    dmem_lsu_if.slave   bus
);
    localparam logic [1:0]  c_idle  = 2'd0;
    localparam logic [1:0]  c_read  = 2'd1;
    localparam logic [1:0]  c_write = 2'd2;
    localparam logic [1:0]  c_resp  = 2'd3;
    localparam logic [31:0] c_limit = 32'(MEM_BYTES);

    logic [1:0]  r_state, w_next_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic [31:0] r_resp_rdata, r_mem_addr, r_mem_wdata;
    logic        r_resp_err;

    logic        w_illegal, w_misalign, w_oor, w_err, w_is_sw, w_accept;
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load, w_mask, w_ins, w_merged;

    always_comb begin
        w_illegal  = bus.req_we ? (bus.req_funct3 > 3'd2)
                                : (bus.req_funct3[1:0] == 2'b11 || bus.req_funct3 == 3'b110);
        w_misalign = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
        w_oor      = bus.req_addr >= c_limit;
        w_err      = w_illegal || w_misalign || w_oor;
        w_is_sw    = bus.req_we && bus.req_funct3 == 3'b010;
        w_accept   = r_state == c_idle && bus.req_valid;
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        w_shift = {r_lane, 3'b000};
        w_byte  = bus.mem_rdata[w_shift +: 8];
        w_half  = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = bus.mem_rdata;
        endcase
        w_mask   = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shift;
        w_ins    = {16'h0, r_wdata} << w_shift;
        w_merged = (bus.mem_rdata & ~w_mask) | (w_ins & w_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_idle;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (bus.req_valid) begin
                    if (w_err)        w_next_state = c_resp;
                    else if (w_is_sw) w_next_state = c_write;
                    else              w_next_state = c_read;
                end
            end
            c_read:  w_next_state = r_we ? c_write : c_resp;
            c_write: w_next_state = c_resp;
            c_resp:  if (bus.resp_ready) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        bus.req_ready  = r_state == c_idle;
        bus.resp_valid = r_state == c_resp;
        bus.mem_we     = r_state == c_write;
        bus.resp_rdata = r_resp_rdata;
        bus.resp_err   = r_resp_err;
        bus.mem_addr   = r_mem_addr;
        bus.mem_wdata  = r_mem_wdata;
    end

    // Request fields are captured once at acceptance; later req_* changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_lane       <= 2'b00;
            r_wdata      <= 16'h0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we         <= bus.req_we;
                r_funct3     <= bus.req_funct3;
                r_lane       <= bus.req_addr[1:0];
                r_wdata      <= bus.req_wdata[15:0];
                r_resp_rdata <= 32'h0;
                r_resp_err   <= w_err;
                if (!w_err)            r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                if (!w_err && w_is_sw) r_mem_wdata <= bus.req_wdata;
            end
            if (r_state == c_read) begin
                if (r_we) r_mem_wdata  <= w_merged;
                else      r_resp_rdata <= w_load;
            end
            if (r_state == c_resp && bus.resp_ready) r_resp_err <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Brief    : Self-checking bench for dmem_lsu: vector table, corner sequences, random ops
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    dmem_lsu_if bus ();
    dmem_lsu #(.MEM_BYTES(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [31:0] init_words [0:7] = '{32'h281E140A, 32'h50463C32, 32'h6665645A, 32'h13579BDF,
                                      32'hC86D6C6B, 32'h2468ACE0, 32'h0F1E2D3C, 32'hDEADBEEF};
    logic [31:0] mem_words [0:7];
    bit          mem_loaded = 1'b0;
    int          we_cnt = 0;
    logic [31:0] last_we_addr = 32'h0;
    logic [31:0] last_we_data = 32'h0;
    logic [7:0]  ref_mem [0:31];

    assign bus.mem_rdata = (bus.mem_addr < 32) ? mem_words[bus.mem_addr[4:2]] : 32'h0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem_words  <= init_words;
            mem_loaded <= 1'b1;
        end else if (bus.mem_we) begin
            if (bus.mem_addr < 32) mem_words[bus.mem_addr[4:2]] <= bus.mem_wdata;
            we_cnt       <= we_cnt + 1;
            last_we_addr <= bus.mem_addr;
            last_we_data <= bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: byte-array memory and the access rules, with plain arithmetic
    task automatic ref_eval(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] er, output logic ee,
                            output int el, output int ep);
        int     size;
        bit     illegal;
        longint val;
        size = 1 << f3[1:0];
        if (we) illegal = (f3 > 3'd2);
        else    illegal = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        er = 32'h0;
        ep = 0;
        ee = illegal || ((addr % size) != 0) || (addr >= 32);
        if (ee) el = 1;
        else if (we) begin
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
            el = (size == 4) ? 2 : 3;
            ep = 1;
        end else begin
            val = 0;
            for (int i = 0; i < size; i++) val += longint'(ref_mem[int'(addr) + i]) << (8 * i);
            if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                val -= (longint'(1) << (8 * size));
            er = val[31:0];
            el = 2;
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                          output int lat, output int pulses);
        int w0;
        @(negedge clk);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        w0 = we_cnt;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(posedge clk); #1;
        pulses = we_cnt - w0;
        check("resp_valid_cleared", 32'(bus.resp_valid), 32'd0);
        check("resp_err_cleared", 32'(bus.resp_err), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_pulses;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [31:0] rd, er;
        logic        e, ee;
        int          lat, pl, el, ep, w0;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        int          size;

        vecs[0]  = '{1'b0, 3'b010, 32'd0,  32'h0,        32'h281E140A, 1'b0, 2, 0};
        vecs[1]  = '{1'b0, 3'b000, 32'd19, 32'h0,        32'hFFFFFFC8, 1'b0, 2, 0};
        vecs[2]  = '{1'b0, 3'b100, 32'd19, 32'h0,        32'h000000C8, 1'b0, 2, 0};
        vecs[3]  = '{1'b0, 3'b001, 32'd18, 32'h0,        32'hFFFFC86D, 1'b0, 2, 0};
        vecs[4]  = '{1'b0, 3'b101, 32'd18, 32'h0,        32'h0000C86D, 1'b0, 2, 0};
        vecs[5]  = '{1'b1, 3'b000, 32'd5,  32'h123456AB, 32'h0,        1'b0, 3, 1};
        vecs[6]  = '{1'b0, 3'b010, 32'd4,  32'h0,        32'h5046AB32, 1'b0, 2, 0};
        vecs[7]  = '{1'b0, 3'b010, 32'd2,  32'h0,        32'h0,        1'b1, 1, 0};
        vecs[8]  = '{1'b0, 3'b010, 32'd32, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[9]  = '{1'b0, 3'b011, 32'd0,  32'h0,        32'h0,        1'b1, 1, 0};
        vecs[10] = '{1'b0, 3'b010, 32'd28, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vecs[11] = '{1'b1, 3'b001, 32'd1,  32'h0000BEEF, 32'h0,        1'b1, 1, 0};
        vecs[12] = '{1'b1, 3'b010, 32'd32, 32'h11111111, 32'h0,        1'b1, 1, 0};
        vecs[13] = '{1'b1, 3'b010, 32'd12, 32'hA5A5F00D, 32'h0,        1'b0, 2, 1};
        vecs[14] = '{1'b0, 3'b010, 32'd12, 32'h0,        32'hA5A5F00D, 1'b0, 2, 0};
        vecs[15] = '{1'b0, 3'b001, 32'd17, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[16] = '{1'b1, 3'b001, 32'd18, 32'hFFFF1234, 32'h0,        1'b0, 3, 1};
        vecs[17] = '{1'b0, 3'b010, 32'd16, 32'h0,        32'h12346C6B, 1'b0, 2, 0};
        vecs[18] = '{1'b1, 3'b100, 32'd0,  32'h22222222, 32'h0,        1'b1, 1, 0};

        for (int i = 0; i < 8; i++)
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = init_words[i][8*b +: 8];

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 19; i++) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, e, lat, pl);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_we_pulses", i), 32'(pl), 32'(vecs[i].exp_pulses));
            if (i == 5) begin
                check("sb5_mem_addr", last_we_addr, 32'd4);
                check("sb5_mem_wdata", last_we_data, 32'h5046AB32);
            end
            ref_eval(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, er, ee, el, ep);
        end

        // Response held off for five cycles
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'd0;
        bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_latency", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_resp_rdata", bus.resp_rdata, 32'h281E140A);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk) bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_req_ready", 32'(bus.req_ready), 32'd1);
        check("hold_release_resp_valid", 32'(bus.resp_valid), 32'd0);
        do_req(1'b0, 3'b010, 32'd4, 32'h0, rd, e, lat, pl);
        check("after_hold_rdata", rd, 32'h5046AB32);
        check("after_hold_latency", 32'(lat), 32'd2);

        // Reset during the read phase of a sub-word store
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_funct3 = 3'b001; bus.req_addr = 32'd8;
        bus.req_wdata = 32'h0000BEEF; bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
        w0 = we_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("arst_resp_err", 32'(bus.resp_err), 32'd0);
        check("arst_resp_rdata", bus.resp_rdata, 32'h0);
        check("arst_mem_we", 32'(bus.mem_we), 32'd0);
        check("arst_mem_addr", bus.mem_addr, 32'h0);
        check("arst_mem_wdata", bus.mem_wdata, 32'h0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_req_ready_after_release", 32'(bus.req_ready), 32'd1);
        check("arst_no_write", 32'(we_cnt - w0), 32'd0);
        do_req(1'b0, 3'b010, 32'd8, 32'h0, rd, e, lat, pl);
        check("arst_word8_intact", rd, 32'h6665645A);

        // Randomized operations against the reference model
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end
            end else f3 = 3'($urandom_range(0, 7));
            size = 1 << f3[1:0];
            case ($urandom_range(0, 7))
                0: addr = $urandom_range(0, 35);
                1: addr = $urandom;
                default: addr = 32'($urandom_range(0, 8) * 4 +
                                    ((size == 1) ? $urandom_range(0, 3) :
                                     (size == 2) ? $urandom_range(0, 1) * 2 : 0));
            endcase
            wd = $urandom;
            ref_eval(we, f3, addr, wd, er, ee, el, ep);
            do_req(we, f3, addr, wd, rd, e, lat, pl);
            check($sformatf("rnd%0d_rdata", n), rd, er);
            check($sformatf("rnd%0d_err", n), 32'(e), 32'(ee));
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(el));
            check($sformatf("rnd%0d_we_pulses", n), 32'(pl), 32'(ep));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
